// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
//
// Shares the single port of a synchronous frame-buffer RAM between the VGA
// scan-out path and a processor. VGA owns the port whenever blank_b=1. The
// processor gets the port only during blanking. If display resumes before the
// access is issued, the access is dropped and retried in the next blanking
// period.
//
// Processor handshake (4-phase req/ack):
//   The processor raises cpu_req and holds cpu_we/cpu_addr/cpu_wdata stable.
//   The arbiter performs exactly one RAM access and pulses cpu_ack for one
//   cycle. For a read, cpu_rdata is valid with that pulse and stays held.
//   The processor then drops cpu_req. A new access starts only after cpu_req
//   has been seen low.
//
// Parameters:
//   ADDR_W : frame-buffer address width (matches pxlAddr)
//   DATA_W : pixel / data width
//
// Ports:
//   vgaclk, reset          : pixel clock; async active-high reset
//   blank_b, pxlAddr       : scan-out timing (1 = active display) and address
//   pix_data               : pixel to DAC, 2-cycle latency, 0 during blanking
//   cpu_req/we/addr/wdata  : processor request (held until cpu_ack)
//   cpu_ack, cpu_rdata     : completion pulse and read data
//   mem_addr/we/wdata      : RAM port
//   mem_rdata              : RAM read data, 1-cycle latency
//   stat_done, stat_abort  : saturating counters (only with FB_ARB_STATS_EN)
//   dbg_state              : current FSM state, for observation
//
// Optional feature macro: FB_ARB_STATS_EN
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              vgaclk,
    input  logic              reset,
    input  logic              blank_b,
    input  logic [ADDR_W-1:0] pxlAddr,
    output logic [DATA_W-1:0] pix_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       stat_done,
    output logic [15:0]       stat_abort,
`endif
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RDWAIT  = 3'd2,
        S_ACK     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   vga_rd_q;
    logic   cpu_owns_port;
    logic   abort;
    logic   rd_capture;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and decoded controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        cpu_owns_port = 1'b0;
        abort         = 1'b0;
        rd_capture    = 1'b0;
        cpu_ack       = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req && !blank_b) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (blank_b) begin
                    // Display resumed before the access went out: drop it
                    // without touching the RAM; it is retried next blanking.
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cpu_owns_port = 1'b1;
                    state_next    = cpu_we ? S_ACK : S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                // The read is already in the RAM pipeline, so blank_b no
                // longer matters here.
                rd_capture = 1'b1;
                state_next = S_ACK;
            end
            S_ACK: begin
                cpu_ack    = 1'b1;
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                // A request still held high must not start a second access.
                if (!cpu_req) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // RAM port mux: the processor drives the port only in ISSUE during
    // blanking; at every other time the scan-out address is presented.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr  = pxlAddr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_owns_port) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // VGA pipeline: blank_b is delayed to line up with the RAM's 1-cycle read
    // latency, so pix_data carries the pixel addressed two cycles earlier.
    // -----------------------------------------------------------------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            vga_rd_q <= 1'b0;
            pix_data <= '0;
        end else begin
            vga_rd_q <= blank_b;
            pix_data <= vga_rd_q ? mem_rdata : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Processor read data capture, held until the next read completes.
    // -----------------------------------------------------------------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
        end else if (rd_capture) begin
            cpu_rdata <= mem_rdata;
        end
    end

`ifdef FB_ARB_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating activity counters.
    // -----------------------------------------------------------------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            stat_done  <= 16'h0000;
            stat_abort <= 16'h0000;
        end else begin
            if (cpu_ack && (stat_done != 16'hFFFF)) begin
                stat_done <= stat_done + 16'h0001;
            end
            if (abort && (stat_abort != 16'hFFFF)) begin
                stat_abort <= stat_abort + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single port of the synchronous frame-buffer RAM between two requesters.
- The VGA scan-out path reads one pixel per vgaclk, driven by pxlAddr/blank_b from the VGA timing controller.
- The processor side issues single-word reads/writes through a 4-phase req/ack handshake.
- VGA always owns the port during active display; processor accesses are scheduled only in blanking, and aborted cleanly if blanking ends before issue.

Parameters:
- ADDR_W, 18, frame-buffer address width (matches pxlAddr).
- DATA_W, 8, pixel/data width.

Ports:
- vgaclk  in  1  pixel clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- blank_b  in  1  1 = active display (VGA owns port), 0 = blanking.
- pxlAddr  in  ADDR_W  scan-out pixel address.
- pix_data  out  DATA_W  pixel to DAC; 0 during blanking.
- cpu_req  in  1  processor request, level; held until cpu_ack seen.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req=1.
- cpu_addr  in  ADDR_W  processor address; stable while cpu_req=1.
- cpu_wdata  in  DATA_W  write data; stable while cpu_req=1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1, held afterwards.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after address.

Behaviour:
- Reset values (async): pix_data=0, cpu_ack=0, cpu_rdata=0, FSM=IDLE, vga_rd_q=0, mem_we=0. mem_addr follows the port mux, so it equals pxlAddr or 0.
- Port mux (combinational):
  - FSM=ISSUE and blank_b=0: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - Otherwise: mem_addr=pxlAddr, mem_we=0, mem_wdata=0.
- VGA pipeline:
  - vga_rd_q <= blank_b.
  - pix_data <= vga_rd_q ? mem_rdata : 0.
  - pix_data reflects the pxlAddr presented 2 cycles earlier. Fixed latency 2, no bubbles.
- FSM states: IDLE, ISSUE, RDWAIT, ACK, RELEASE.
  - IDLE -> ISSUE when cpu_req=1 and blank_b=0.
  - ISSUE, blank_b=1 (display resumed): abort, no RAM access, -> IDLE. Request retried in the next blanking period.
  - ISSUE, blank_b=0, cpu_we=1: write performed this cycle, -> ACK.
  - ISSUE, blank_b=0, cpu_we=0: -> RDWAIT.
  - RDWAIT: cpu_rdata <= mem_rdata; -> ACK. RDWAIT ignores blank_b because the read was already issued.
  - ACK: cpu_ack=1 for exactly this cycle; -> RELEASE.
  - RELEASE: wait for cpu_req=0, then -> IDLE. A held req never triggers a second access.
- Latency in blanking:
  - Write: req seen in IDLE -> ack 2 cycles later.
  - Read: req seen in IDLE -> ack 3 cycles later.
- At most one processor access is in flight; the processor never stalls the VGA path.
- Reset mid-operation returns to IDLE with cpu_ack=0. The processor must re-request.
- A processor write to the address VGA is currently showing takes effect on the next frame's read of that address.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- Defined: adds outputs stat_done [15:0] and stat_abort [15:0], both reset to 0.
  - stat_done increments on each cpu_ack.
  - stat_abort increments on each ISSUE->IDLE abort.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted mid-RDWAIT -> cpu_ack=0, pix_data=0, FSM IDLE immediately (async). After release, a fresh req completes normally.
- blank_b=1, pxlAddr sequence 0,1,2 with RAM holding 8'h10,8'h11,8'h12 -> pix_data = 10,11,12 starting 2 cycles later; mem_we stays 0.
- blank_b=0, write req addr 18'h00123, data 8'hA5 -> mem_we=1 with mem_addr=00123 for one cycle; cpu_ack 2 cycles after req; RAM readback = A5.
- blank_b=0, read req addr 18'h00123 -> cpu_ack 3 cycles after req with cpu_rdata=8'hA5; cpu_req held 5 more cycles -> no further access and no second ack.
- Req raised one cycle before blank_b goes 1 (FSM reaches ISSUE while blank_b=1) -> no RAM write, no ack, pix_data stream uninterrupted. Access completes in the next blanking period; with FB_ARB_STATS_EN defined, stat_abort=1 and stat_done=1.
